// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multi-port register file.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

  typedef enum logic {
    StInit,
    StRun
  } state_e;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefDepth = 32;
  localparam int unsigned DefNread = 2;

endpackage

// File: rtl/regfile_rdport.sv
// One asynchronous read port: zero-register detect, storage select and, when
// REGFILE_BYPASS_EN is defined, same-cycle forwarding of the pending write.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             run,
`ifdef REGFILE_BYPASS_EN
  input  logic             byp_en,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
`endif
  input  logic [AW-1:0]    ra,
  input  logic [WIDTH-1:0] mem [DEPTH-1:1],
  output logic [WIDTH-1:0] rd
);

  always_comb begin
    rd = '0;
    if (run && ra != '0) begin
`ifdef REGFILE_BYPASS_EN
      if (byp_en && ra == wa) rd = wd;
      else                    rd = mem[ra];
`else
      rd = mem[ra];
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NREAD async read ports, one sync write port,
// entry 0 hardwired to zero, hardware clear after reset. Bypass: REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned NREAD = DefNread,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [WIDTH-1:0]       wd,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd,
  output logic                   ready
);

  state_e           state_q;
  logic [AW-1:0]    clr_ptr_q;
  logic             ready_q;
  logic [WIDTH-1:0] mem_q [DEPTH-1:1];
  logic             run;

  assign run   = (state_q == StRun);
  assign ready = ready_q;

  // Clear sequencer: walks entries 1..DEPTH-1 once per reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StInit;
      clr_ptr_q <= AW'(1);
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        StInit: begin
          if (clr_ptr_q == AW'(DEPTH - 1)) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end else begin
            clr_ptr_q <= clr_ptr_q + AW'(1);
          end
        end
        StRun:   ;
        default: state_q <= StInit;
      endcase
    end
  end

  // Storage has no reset; its contents are defined by the clear sequence.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem_q[clr_ptr_q] <= '0;
    end else if (we && wa != '0) begin
      mem_q[wa] <= wd;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_en;
  assign byp_en = run && we && (wa != '0);
`endif

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    regfile_rdport #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_rdport (
      .run   (run),
`ifdef REGFILE_BYPASS_EN
      .byp_en(byp_en),
      .wa    (wa),
      .wd    (wd),
`endif
      .ra    (ra[i*AW +: AW]),
      .mem   (mem_q),
      .rd    (rd[i*WIDTH +: WIDTH])
    );
  end

endmodule
